sl_preceptron_mac_lanes: RTL and testbench
==========================================

SL_PRECEPTRON_MAC_LANES -- requirements
Module: sl_preceptron_mac_lanes

Interface
REQ-001 SHALL have parameter LANES, default 4: parallel data/weight lanes per beat.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: signed two's-complement width of each data lane.
REQ-003 SHALL have parameter WEIGHT_WIDTH, default 8: signed width of each weight lane.
REQ-004 SHALL have parameter ADDR_WIDTH, default 16: weight memory address width.
REQ-005 SHALL have parameter SUM_WIDTH, default 24: signed accumulator and sum width, at least DATA_WIDTH+WEIGHT_WIDTH+clog2(LANES).
REQ-006 SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have port start, input, 1: one-cycle pulse that begins a vector.
REQ-009 SHALL have port cfg_vector_len, input, ADDR_WIDTH: beats per vector.
REQ-010 SHALL have port cfg_bias, input, SUM_WIDTH: signed initial accumulator value.
REQ-011 SHALL have port cfg_threshold, input, SUM_WIDTH: signed comparator threshold.
REQ-012 SHALL have port cfg_relu, input, 1: 1 clamps a negative final sum to 0.
REQ-013 SHALL have port in_valid, input, 1: in_data holds a beat.
REQ-014 SHALL have port in_ready, output, 1: block accepts a beat this cycle.
REQ-015 SHALL have port in_data, input, LANES*DATA_WIDTH: lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-016 SHALL have port mem_ren, output, 1: weight read enable.
REQ-017 SHALL have port mem_addr, output, ADDR_WIDTH: weight word address.
REQ-018 SHALL have port mem_rdata, input, LANES*WEIGHT_WIDTH: word at the address issued the previous cycle, packed like in_data.
REQ-019 SHALL have port busy, output, 1: high from start acceptance until done.
REQ-020 SHALL have port done, output, 1: one-cycle pulse when results update.
REQ-021 SHALL have port status_sum, output, SUM_WIDTH: final signed sum.
REQ-022 SHALL have port status_cmp, output, 1: final sum > threshold.
REQ-023 SHALL have port status_sat, output, 1: accumulator saturated during the vector.

Function
REQ-024 SHALL implement states IDLE, FETCH, RUN, DRAIN, DONE.
REQ-025 SHALL, on start in IDLE, latch all cfg_* inputs, load accumulator with cfg_bias, clear beat counter k and sat flag, and enter FETCH; start outside IDLE SHALL be ignored.
REQ-026 SHALL, in FETCH, drive mem_ren=1 and mem_addr=0, then enter RUN; if latched len=0, SHALL skip to DRAIN.
REQ-027 SHALL, in RUN, drive in_ready=1, mem_ren=1, and combinational mem_addr=k+1 on accept (in_valid&in_ready), otherwise mem_addr=k, so mem_rdata always holds weight word k.
REQ-028 SHALL, on accept of the beat with k=len-1, deassert in_ready next cycle, issue no further reads, and enter DRAIN.
REQ-029 SHALL never drive in_ready high outside RUN.
REQ-030 SHALL pipeline: stage 1 registers LANES signed products; stage 2 registers their full-precision signed sum; stage 3 adds it to the accumulator.
REQ-031 SHALL saturate accumulator addition to SUM_WIDTH signed max/min and set status_sat sticky for the vector.
REQ-032 SHALL stay in DRAIN until the pipeline is empty, then enter DONE for one cycle and return to IDLE.
REQ-033 SHALL assert done, update status_sum (ReLU-clamped if latched cfg_relu), and update status_sat in the cycle 4 cycles after the final accept edge (len=0: 3 cycles after FETCH); status_cmp SHALL compare the post-ReLU sum with the latched threshold, signed.
REQ-034 SHALL hold status_* between done pulses.
REQ-035 SHALL drive busy high from the cycle after start acceptance through the done cycle.

Reset
REQ-036 SHALL, on rst, return to IDLE, clear pipeline, and drive every output to 0 (in_ready, mem_ren, mem_addr, busy, done, status_sum, status_cmp, status_sat), overriding any in-flight vector.
REQ-037 SHALL accept start on the first cycle after rst deasserts.

Verification
REQ-038 len=2, bias=0, all data lanes 1, weights 2, threshold 10, no stalls -> status_sum=16, status_cmp=1, done 4 cycles after second accept.
REQ-039 Same vector, in_valid pattern 1,0,1 -> status_sum=16; mem_addr held at 1 during stall cycle.
REQ-040 len=1, bias=5, data -128, weights 127, relu=0, threshold 0 -> status_sum=-65019, cmp=0; relu=1 -> status_sum=0, cmp=0.
REQ-041 len=128, bias=0, data -128, weights -128 -> status_sum=8388607, status_sat=1, cmp=1 at threshold 0.
REQ-042 len=0, bias=-3 -> done with status_sum=-3, no in_ready, one mem_ren in FETCH.
REQ-043 rst asserted after beat 5 of len=10 -> all outputs 0 next cycle; new start with scenario REQ-038 -> status_sum=16.

Source files
------------

// File: rtl/sl_preceptron_mac_lanes.sv
`default_nettype none
// ============================================================================
// Module   : sl_preceptron_mac_lanes
// Brief    : Multi-lane perceptron MAC. Streams data beats against weight words
//            from memory, saturating accumulate, optional ReLU, threshold compare.
// Revision : 1.0 - initial release
// ============================================================================
module sl_preceptron_mac_lanes #(
    parameter int LANES        = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ADDR_WIDTH   = 16,
    parameter int SUM_WIDTH    = 24
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [ADDR_WIDTH-1:0]           cfg_vector_len,
    input  logic [SUM_WIDTH-1:0]            cfg_bias,
    input  logic [SUM_WIDTH-1:0]            cfg_threshold,
    input  logic                            cfg_relu,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]     in_data,
    output logic                            mem_ren,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    input  logic [LANES*WEIGHT_WIDTH-1:0]   mem_rdata,
    output logic                            busy,
    output logic                            done,
    output logic [SUM_WIDTH-1:0]            status_sum,
    output logic                            status_cmp,
    output logic                            status_sat
);

    localparam int c_PROD_W = DATA_WIDTH + WEIGHT_WIDTH;
    localparam int c_PSUM_W = c_PROD_W + $clog2(LANES);
    localparam int c_EXT_W  = SUM_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0]       c_ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic signed [SUM_WIDTH-1:0] c_SUM_MAX  = {1'b0, {(SUM_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_WIDTH-1:0] c_SUM_MIN  = {1'b1, {(SUM_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                        r_state;
    logic [ADDR_WIDTH-1:0]         r_k;
    logic [ADDR_WIDTH-1:0]         r_len;
    logic signed [SUM_WIDTH-1:0]   r_thr;
    logic                          r_relu;
    logic                          r_v1;
    logic                          r_v2;
    logic signed [c_PROD_W-1:0]    r_prod [LANES];
    logic signed [c_PSUM_W-1:0]    r_psum;
    logic signed [SUM_WIDTH-1:0]   r_acc;
    logic                          r_sat;
    logic                          r_done;
    logic signed [SUM_WIDTH-1:0]   r_status_sum;
    logic                          r_status_cmp;
    logic                          r_status_sat;

    logic                          w_accept;
    logic                          w_start;
    logic                          w_inject;
    logic [ADDR_WIDTH-1:0]         w_k_inc;
    logic                          w_last;
    logic signed [c_PROD_W-1:0]    w_prod [LANES];
    logic signed [c_PSUM_W-1:0]    w_psum;
    logic signed [c_EXT_W-1:0]     w_acc_sum;
    logic                          w_ovf;
    logic signed [SUM_WIDTH-1:0]   w_acc_next;
    logic signed [SUM_WIDTH-1:0]   w_final;
    logic                          w_cmp;

    assign w_accept = in_valid && (r_state == S_RUN);
    assign w_start  = start && (r_state == S_IDLE);
    // An empty vector pushes a zero partial sum into stage 2 so its done
    // timing falls out of the normal pipeline drain.
    assign w_inject = (r_state == S_FETCH) && (r_len == '0);
    assign w_k_inc  = r_k + c_ADDR_ONE;
    assign w_last   = (w_k_inc == r_len);

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign w_prod[gi] = c_PROD_W'($signed(in_data[gi*DATA_WIDTH +: DATA_WIDTH]))
                              * c_PROD_W'($signed(mem_rdata[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
        end
    endgenerate

    always_comb begin
        w_psum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_psum = w_psum + c_PSUM_W'(r_prod[i]);
        end
    end

    // One guard bit above the accumulator detects overflow in either direction.
    assign w_acc_sum  = c_EXT_W'(r_acc) + c_EXT_W'(r_psum);
    assign w_ovf      = w_acc_sum[c_EXT_W-1] != w_acc_sum[c_EXT_W-2];
    assign w_acc_next = w_ovf ? (w_acc_sum[c_EXT_W-1] ? c_SUM_MIN : c_SUM_MAX)
                              : w_acc_sum[SUM_WIDTH-1:0];

    assign w_final = (r_relu && r_acc[SUM_WIDTH-1]) ? '0 : r_acc;
    assign w_cmp   = w_final > r_thr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_psum <= '0;
            r_acc  <= '0;
            r_sat  <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                r_prod[i] <= '0;
            end
        end else begin
            r_v1 <= w_accept;
            if (w_accept) begin
                for (int i = 0; i < LANES; i++) begin
                    r_prod[i] <= w_prod[i];
                end
            end
            r_v2 <= r_v1 || w_inject;
            if (w_inject) begin
                r_psum <= '0;
            end else if (r_v1) begin
                r_psum <= w_psum;
            end
            if (w_start) begin
                r_acc <= cfg_bias;
                r_sat <= 1'b0;
            end else if (r_v2) begin
                r_acc <= w_acc_next;
                if (w_ovf) begin
                    r_sat <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_k          <= '0;
            r_len        <= '0;
            r_thr        <= '0;
            r_relu       <= 1'b0;
            r_done       <= 1'b0;
            r_status_sum <= '0;
            r_status_cmp <= 1'b0;
            r_status_sat <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len   <= cfg_vector_len;
                        r_thr   <= cfg_threshold;
                        r_relu  <= cfg_relu;
                        r_k     <= '0;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_state <= (r_len == '0) ? S_DRAIN : S_RUN;
                end
                S_RUN: begin
                    if (in_valid) begin
                        r_k <= w_k_inc;
                        if (w_last) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!r_v1 && !r_v2) begin
                        r_state      <= S_DONE;
                        r_done       <= 1'b1;
                        r_status_sum <= w_final;
                        r_status_cmp <= w_cmp;
                        r_status_sat <= r_sat;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Address look-ahead keeps mem_rdata aligned with the beat being offered.
    assign in_ready   = (r_state == S_RUN);
    assign mem_ren    = (r_state == S_FETCH) || (r_state == S_RUN);
    assign mem_addr   = (r_state == S_RUN) ? (in_valid ? w_k_inc : r_k) : '0;
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign status_sum = r_status_sum;
    assign status_cmp = r_status_cmp;
    assign status_sat = r_status_sat;

endmodule
`default_nettype wire

// File: tb/tb_sl_preceptron_mac_lanes.sv
`default_nettype none
// ============================================================================
// Module   : tb_sl_preceptron_mac_lanes
// Brief    : Directed and randomized self-checking bench against an arithmetic
//            reference model of the perceptron MAC.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sl_preceptron_mac_lanes;

    localparam int     c_LANES = 4;
    localparam int     c_DW    = 8;
    localparam int     c_AW    = 16;
    localparam int     c_SW    = 24;
    localparam longint c_MAX   = 64'sd8388607;
    localparam longint c_MIN   = -64'sd8388608;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic [c_AW-1:0]       cfg_vector_len = '0;
    logic [c_SW-1:0]       cfg_bias = '0;
    logic [c_SW-1:0]       cfg_threshold = '0;
    logic                  cfg_relu = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [31:0]           in_data = '0;
    logic                  mem_ren;
    logic [c_AW-1:0]       mem_addr;
    logic [31:0]           mem_rdata = '0;
    logic                  busy;
    logic                  done;
    logic [c_SW-1:0]       status_sum;
    logic                  status_cmp;
    logic                  status_sat;

    logic [31:0]           dmem [256];
    logic [31:0]           wmem [256];
    int                    checks = 0;
    int                    failures = 0;
    longint                prev_sum = 0;

    sl_preceptron_mac_lanes dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .cfg_vector_len (cfg_vector_len),
        .cfg_bias       (cfg_bias),
        .cfg_threshold  (cfg_threshold),
        .cfg_relu       (cfg_relu),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .mem_ren        (mem_ren),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .busy           (busy),
        .done           (done),
        .status_sum     (status_sum),
        .status_cmp     (status_cmp),
        .status_sat     (status_sat)
    );

    always #5 clk = ~clk;

    // Synchronous weight memory: data appears the cycle after the read.
    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= wmem[mem_addr[7:0]];
    end

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model(input int len, input longint bias, input longint thr, input bit relu,
                         output longint sum, output bit cmp, output bit sat);
        longint acc;
        longint s;
        acc = bias;
        sat = 1'b0;
        for (int b = 0; b < len; b++) begin
            s = 0;
            for (int i = 0; i < c_LANES; i++) begin
                s += longint'($signed(dmem[b][i*c_DW +: c_DW])) * longint'($signed(wmem[b][i*c_DW +: c_DW]));
            end
            acc += s;
            if (acc > c_MAX) begin
                acc = c_MAX;
                sat = 1'b1;
            end else if (acc < c_MIN) begin
                acc = c_MIN;
                sat = 1'b1;
            end
        end
        if (relu && acc < 0) acc = 0;
        sum = acc;
        cmp = (acc > thr);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_mem_ren"}, mem_ren, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_status_sum"}, status_sum, 0);
        check({tag, "_status_cmp"}, status_cmp, 0);
        check({tag, "_status_sat"}, status_sat, 0);
    endtask

    // Called at a falling edge; mode 0 = always valid, 1 = random gaps, 2 = valid on odd cycles.
    task automatic run_vec(input string name, input int len, input longint bias, input longint thr,
                           input bit relu, input int mode);
        longint          e_sum;
        bit              e_cmp;
        bit              e_sat;
        int              beat;
        int              cyc;
        int              acc_cyc;
        int              done_cyc;
        int              ren_cnt;
        int              rdy_cnt;
        logic [c_AW-1:0] e_addr;
        model(len, bias, thr, relu, e_sum, e_cmp, e_sat);
        cfg_vector_len = c_AW'(len);
        cfg_bias       = c_SW'(bias);
        cfg_threshold  = c_SW'(thr);
        cfg_relu       = relu;
        start          = 1'b1;
        @(posedge clk); #1;
        start          = 1'b0;
        cfg_vector_len = c_AW'($urandom);
        cfg_bias       = c_SW'($urandom);
        cfg_threshold  = c_SW'($urandom);
        cfg_relu       = 1'($urandom);
        beat = 0; cyc = 0; acc_cyc = -1; done_cyc = -1; ren_cnt = 0; rdy_cnt = 0;
        check({name, "_prev_status_held"}, $signed(status_sum), prev_sum);
        check({name, "_fetch_ready_low"}, in_ready, 0);
        while (done_cyc < 0 && cyc < 8*len + 40) begin
            in_valid = (beat < len) && ((mode == 0) ||
                                        (mode == 1 && $urandom_range(0, 3) != 0) ||
                                        (mode == 2 && cyc % 2 == 1));
            in_data  = dmem[beat[7:0]];
            @(negedge clk);
            check({name, "_busy"}, busy, 1);
            if (mem_ren) begin
                ren_cnt++;
                e_addr = c_AW'(beat + ((in_ready && in_valid) ? 1 : 0));
                check({name, "_mem_addr"}, mem_addr, e_addr);
            end
            if (in_ready) rdy_cnt++;
            if (done) done_cyc = cyc;
            if (in_ready && in_valid) begin
                acc_cyc = cyc;
                beat++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        check({name, "_done_seen"}, (done_cyc >= 0), 1);
        check({name, "_beats"}, beat, len);
        check({name, "_done_cycle"}, done_cyc, (len > 0) ? acc_cyc + 4 : 3);
        check({name, "_ren_count"}, ren_cnt, (len > 0) ? acc_cyc + 1 : 1);
        check({name, "_ready_count"}, rdy_cnt, (len > 0) ? acc_cyc : 0);
        check({name, "_sum"}, $signed(status_sum), e_sum);
        check({name, "_cmp"}, status_cmp, e_cmp);
        check({name, "_sat"}, status_sat, e_sat);
        @(negedge clk);
        check({name, "_done_pulse"}, done, 0);
        check({name, "_busy_after"}, busy, 0);
        prev_sum = e_sum;
    endtask

    initial begin
        int     nb;
        int     len;
        longint bias;
        longint thr;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        for (int b = 0; b < 2; b++) begin
            dmem[b] = {4{8'd1}};
            wmem[b] = {4{8'd2}};
        end
        run_vec("basic", 2, 0, 10, 1'b0, 0);
        run_vec("stall", 2, 0, 10, 1'b0, 2);

        dmem[0] = {4{8'h80}};
        wmem[0] = {4{8'h7f}};
        run_vec("neg", 1, 5, 0, 1'b0, 0);
        run_vec("relu", 1, 5, 0, 1'b1, 1);

        for (int b = 0; b < 128; b++) begin
            dmem[b] = {4{8'h80}};
            wmem[b] = {4{8'h80}};
        end
        run_vec("sat_pos", 128, 0, 0, 1'b0, 0);
        run_vec("empty", 0, -3, 0, 1'b0, 0);

        for (int t = 0; t < 6; t++) begin
            len  = int'($urandom_range(1, 12));
            for (int b = 0; b < len; b++) begin
                dmem[b] = $urandom;
                wmem[b] = $urandom;
            end
            bias = longint'($urandom_range(0, 200000)) - 100000;
            thr  = longint'($urandom_range(0, 200000)) - 100000;
            run_vec("rand", len, bias, thr, 1'($urandom), int'($urandom_range(0, 2)));
        end

        for (int b = 0; b < 128; b++) begin
            dmem[b] = {4{8'h80}};
            wmem[b] = {4{8'h7f}};
        end
        run_vec("sat_neg", 128, -1000000, 0, 1'b0, 1);

        for (int b = 0; b < 10; b++) begin
            dmem[b] = $urandom;
            wmem[b] = $urandom;
        end
        cfg_vector_len = 16'd10;
        cfg_bias       = '0;
        cfg_threshold  = '0;
        cfg_relu       = 1'b0;
        start          = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nb = 0;
        for (int g = 0; g < 40 && nb < 5; g++) begin
            in_valid = 1'b1;
            in_data  = dmem[nb[7:0]];
            @(negedge clk);
            if (in_ready) nb++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("rst_mid_beats", nb, 5);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        rst      = 1'b0;
        prev_sum = 0;
        for (int b = 0; b < 2; b++) begin
            dmem[b] = {4{8'd1}};
            wmem[b] = {4{8'd2}};
        end
        run_vec("after_rst", 2, 0, 10, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
